// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory response record, error-bit
// positions and default sizing for the instruction-memory responder.
package cpu_pkg;

  localparam int IMEM_DEPTH   = 1024;
  localparam int IMEM_MAX_OUT = 4;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } imem_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// In-order response buffer with modulo-DEPTH pointers, plus its overflow checker.
module rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output T              head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = next_ptr(wr_q);
    else        wr_d = wr_q;
    if (pop_i)  rd_d = next_ptr(rd_q);
    else        rd_d = rd_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign empty_o = (cnt_q == CW'(0));
  assign full_s  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  rsp_fifo_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_i),
    .full_i (full_s)
  );

endmodule

module rsp_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push_i,
  input logic full_i
);

  // Admission control upstream must never let a push land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push_i && full_i));

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a fixed two-stage read pipeline feeding an in-order
// response buffer; admission is throttled so the buffer can never overflow.
module imem_responder import cpu_pkg::*; #(
  parameter int  DEPTH   = IMEM_DEPTH,
  parameter int  MAX_OUT = IMEM_MAX_OUT,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [1:0]    rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int OW = $clog2(MAX_OUT + 3);

  logic [31:0]   mem_q [DEPTH];

  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_idx_q;
  logic [1:0]    s1_err_q;
  logic          s1_hit_q;
  logic [31:0]   s1_old_q;
  logic          s2_valid_q, s2_valid_d;
  imem_rsp_t     s2_rsp_q, s2_rsp_d;

  logic [1:0]    req_err_s;
  logic [AW-1:0] req_idx_s;
  logic          accept_s;
  logic [OW-1:0] outstanding_s;
  logic [CW-1:0] fifo_cnt_s;
  logic          fifo_empty_s;
  logic          pop_s;
  imem_rsp_t     head_s;
  logic [31:0]   rd_data_s;

  always_comb begin
    req_err_s               = 2'b00;
    req_err_s[ERR_MISALIGN] = |req_addr[1:0];
    req_err_s[ERR_RANGE]    = |req_addr[63:AW+2];
  end

  assign req_idx_s     = req_addr[AW+1:2];
  assign outstanding_s = OW'(s1_valid_q) + OW'(s2_valid_q) + OW'(fifo_cnt_s);
  assign req_ready     = !reset && (outstanding_s < OW'(MAX_OUT));
  assign accept_s      = req_valid && req_ready;

  // A load in the accept cycle must not leak into that request: keep the old word.
  assign rd_data_s = s1_hit_q ? s1_old_q : mem_q[s1_idx_q];

  always_comb begin
    s1_valid_d = accept_s;
    s2_valid_d = s1_valid_q;
    s2_rsp_d.err = s1_err_q;
    if (s1_err_q != 2'b00) s2_rsp_d.instr = 32'd0;
    else                   s2_rsp_d.instr = rd_data_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_idx_q <= req_idx_s;
    s1_err_q <= req_err_s;
    s1_hit_q <= ld_en && (ld_addr == req_idx_s);
    s1_old_q <= mem_q[ld_addr];
    s2_rsp_q <= s2_rsp_d;
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  assign pop_s     = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty_s;
  assign rsp_instr = rsp_valid ? head_s.instr : 32'd0;
  assign rsp_err   = rsp_valid ? head_s.err   : 2'b00;

  rsp_fifo #(
    .DEPTH (MAX_OUT),
    .T     (imem_rsp_t)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (s2_valid_q),
    .push_data_i (s2_rsp_q),
    .pop_i       (pop_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_cnt_s),
    .head_o      (head_s)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, back-pressure, error codes,
// read-first load behaviour and reset flush.
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [1:0]    rsp_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pop_instr_q[$];
  logic [1:0]  pop_err_q[$];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(DEPTH), .MAX_OUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Records any pop the coming edge will perform, then advances one cycle.
  task automatic step();
    if (rsp_valid && rsp_ready) begin
      pop_instr_q.push_back(rsp_instr);
      pop_err_q.push_back(rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = AW'(idx); ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic send(input logic [63:0] a);
    int t;
    req_valid = 1'b1; req_addr = a;
    for (t = 0; t < 40 && !req_ready; t++) step();
    if (!req_ready) chk("send_timeout", 64'(t), 64'd0);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int t = 0; t < 60 && pop_instr_q.size() < n; t++) step();
    chk("drain_count", 64'(pop_instr_q.size()), 64'(n));
  endtask

  task automatic expect_pops(input string tag, input logic [31:0] ei[$], input logic [1:0] ee[$]);
    for (int i = 0; i < ei.size() && i < pop_instr_q.size(); i++) begin
      chk($sformatf("%s_instr%0d", tag, i), 64'(pop_instr_q[i]), 64'(ei[i]));
      chk($sformatf("%s_err%0d", tag, i), 64'(pop_err_q[i]), 64'(ee[i]));
    end
    pop_instr_q.delete();
    pop_err_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int k;
    reset = 1'b1; req_valid = 1'b0; req_addr = 64'd0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    #1;
    chk("release_ready", 64'(req_ready), 64'd1);

    load(0, 32'h11111111); load(1, 32'h22222222); load(2, 32'h33333333);
    load(3, 32'h44444444); load(4, 32'h55555555); load(5, 32'h66666666);

    // Back-to-back fetch: first response visible after accept edge + 2.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 4);
      req_addr  = 64'(i * 4);
      if (i < 4) chk($sformatf("b2b_ready%0d", i), 64'(req_ready), 64'd1);
      step();
      if (i >= 2 && i < 6) begin
        w = 32'h11111111 * 32'(i - 1);
        chk($sformatf("b2b_valid%0d", i), 64'(rsp_valid), 64'd1);
        chk($sformatf("b2b_instr%0d", i), 64'(rsp_instr), 64'(w));
        chk($sformatf("b2b_err%0d", i), 64'(rsp_err), 64'd0);
      end else begin
        chk($sformatf("b2b_idle%0d", i), 64'(rsp_valid), 64'd0);
      end
    end
    req_valid = 1'b0;
    pop_instr_q.delete(); pop_err_q.delete();

    // Stalled consumer: six offered, only four admitted, head held stable.
    rsp_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (k < 6);
      req_addr  = 64'(k * 4);
      if (req_valid && req_ready) begin
        step(); k++;
      end else begin
        step();
      end
      if (rsp_valid) chk($sformatf("stall_hold%0d", i), 64'(rsp_instr), 64'h11111111);
    end
    chk("stall_accepts", 64'(k), 64'd4);
    chk("stall_ready", 64'(req_ready), 64'd0);
    chk("stall_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    for (int t = 0; t < 40 && (k < 6 || pop_instr_q.size() < 6); t++) begin
      req_valid = (k < 6);
      req_addr  = 64'(k * 4);
      if (req_valid && req_ready) begin
        step(); k++;
      end else begin
        step();
      end
    end
    req_valid = 1'b0;
    chk("stall_total_acc", 64'(k), 64'd6);
    chk("stall_pops", 64'(pop_instr_q.size()), 64'd6);
    expect_pops("stall", '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                           32'h55555555, 32'h66666666},
                         '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    // Error codes interleaved with good fetches.
    send(64'h6); send(64'h4); send(64'(DEPTH * 4)); send(64'h8); send(64'(DEPTH * 4 + 2));
    drain(5);
    expect_pops("err", '{32'h0, 32'h22222222, 32'h0, 32'h33333333, 32'h0},
                       '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11});

    // Load and fetch of word 5 in the same cycle returns the old word.
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 64'd20;
    chk("rf_ready", 64'(req_ready), 64'd1);
    step();
    ld_en = 1'b0; req_valid = 1'b0;
    drain(1);
    expect_pops("rf_old", '{32'h66666666}, '{2'b00});
    send(64'd20);
    drain(1);
    expect_pops("rf_new", '{32'hDEADBEEF}, '{2'b00});

    // Reset with three responses in flight.
    rsp_ready = 1'b0;
    send(64'd0); send(64'd4); send(64'd8);
    reset = 1'b1;
    step(); step();
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_instr", 64'(rsp_instr), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("no_stale", 64'(pop_instr_q.size()), 64'd0);
    send(64'd4); send(64'd12);
    drain(2);
    expect_pops("post_rst", '{32'h22222222, 32'h44444444}, '{2'b00, 2'b00});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
